// File: rtl/mem_hier_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_hier_top                                                  |
// | Purpose  : four-port write-through / write-invalidate L1 hierarchy with  |
// |            4-way set-associative private caches over one backing store.  |
// | Options  : HIT_STATUS_EN adds registered per-port hit flags (hit_proc).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mem_hier_top #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int SET_BITS   = 4,
    parameter int MEM_AW     = 10
) (
    input  logic                  plusclk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_proc_0,
    input  logic [ADDR_WIDTH-1:0] addr_proc_1,
    input  logic [ADDR_WIDTH-1:0] addr_proc_2,
    input  logic [ADDR_WIDTH-1:0] addr_proc_3,
    input  logic [DATA_WIDTH-1:0] din_proc_0,
    input  logic [DATA_WIDTH-1:0] din_proc_1,
    input  logic [DATA_WIDTH-1:0] din_proc_2,
    input  logic [DATA_WIDTH-1:0] din_proc_3,
    output logic [DATA_WIDTH-1:0] dout_proc_0,
    output logic [DATA_WIDTH-1:0] dout_proc_1,
    output logic [DATA_WIDTH-1:0] dout_proc_2,
    output logic [DATA_WIDTH-1:0] dout_proc_3
`ifdef HIT_STATUS_EN
    ,
    output logic [3:0]            hit_proc
`endif
);

    localparam int NP        = 4;
    localparam int NW        = 4;
    localparam int NSETS     = 1 << SET_BITS;
    localparam int IN_W      = ADDR_WIDTH - 2;
    localparam int LOW_W     = ADDR_WIDTH - 4;
    localparam int TAG_W     = LOW_W - SET_BITS;
    localparam int MEM_WORDS = 1 << MEM_AW;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;
    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;

    logic [IN_W-1:0]       addr_in     [NP];
    logic [DATA_WIDTH-1:0] din_in      [NP];
    logic                  unused_pid;

    logic [0:0]            state_q     [NP];
    logic [LOW_W-1:0]      fill_addr_q [NP];
    logic [DATA_WIDTH-1:0] dout_q      [NP];
    logic [NW-1:0]         valid_q     [NP][NSETS];
    logic [1:0]            ptr_q       [NP][NSETS];
    logic [TAG_W-1:0]      tag_q       [NP][NSETS][NW];
    logic [DATA_WIDTH-1:0] data_q      [NP][NSETS][NW];
    logic [DATA_WIDTH-1:0] mem_q       [MEM_WORDS];

    logic [LOW_W-1:0]      cur_addr    [NP];
    logic [SET_BITS-1:0]   set_c       [NP];
    logic [TAG_W-1:0]      tag_c       [NP];
    logic [MEM_AW-1:0]     idx_c       [NP];
    logic [1:0]            hit_way_c   [NP];
    logic [1:0]            vict_c      [NP];
    logic [1:0]            inst_way_c  [NP];
    logic [DATA_WIDTH-1:0] hit_data_c  [NP];
    logic [DATA_WIDTH-1:0] fill_data_c [NP];
    logic [DATA_WIDTH-1:0] line_data_c [NP];
    logic [NP-1:0]         rd_c, wr_c, fill_c, hit_c, evict_c, win_c, xinv_c;

    assign addr_in[0] = addr_proc_0[IN_W-1:0];
    assign addr_in[1] = addr_proc_1[IN_W-1:0];
    assign addr_in[2] = addr_proc_2[IN_W-1:0];
    assign addr_in[3] = addr_proc_3[IN_W-1:0];
    assign din_in[0]  = din_proc_0;
    assign din_in[1]  = din_proc_1;
    assign din_in[2]  = din_proc_2;
    assign din_in[3]  = din_proc_3;
    assign unused_pid = ^{addr_proc_0[ADDR_WIDTH-1:IN_W], addr_proc_1[ADDR_WIDTH-1:IN_W],
                          addr_proc_2[ADDR_WIDTH-1:IN_W], addr_proc_3[ADDR_WIDTH-1:IN_W]};

    assign dout_proc_0 = dout_q[0];
    assign dout_proc_1 = dout_q[1];
    assign dout_proc_2 = dout_q[2];
    assign dout_proc_3 = dout_q[3];

    // A filling port works on its latched address; an idle port on the live one.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            cur_addr[p] = (state_q[p] == ST_FILL) ? fill_addr_q[p] : addr_in[p][LOW_W-1:0];
            set_c[p]    = cur_addr[p][SET_BITS-1:0];
            tag_c[p]    = cur_addr[p][LOW_W-1:SET_BITS];
            idx_c[p]    = cur_addr[p][MEM_AW-1:0];
            rd_c[p]     = (state_q[p] == ST_IDLE) && (addr_in[p][IN_W-1:IN_W-2] == OP_RD);
            wr_c[p]     = !rst && (state_q[p] == ST_IDLE) && (addr_in[p][IN_W-1:IN_W-2] == OP_WR);
            fill_c[p]   = (state_q[p] == ST_FILL);
            hit_c[p]     = 1'b0;
            hit_way_c[p] = 2'd0;
            vict_c[p]    = ptr_q[p][set_c[p]];
            for (int w = NW - 1; w >= 0; w--) begin
                if (valid_q[p][set_c[p]][w] && (tag_q[p][set_c[p]][w] == tag_c[p])) begin
                    hit_c[p]     = 1'b1;
                    hit_way_c[p] = 2'(w);
                end
                if (!valid_q[p][set_c[p]][w]) begin
                    vict_c[p] = 2'(w);
                end
            end
            hit_data_c[p] = data_q[p][set_c[p]][hit_way_c[p]];
            evict_c[p]    = &valid_q[p][set_c[p]];
            inst_way_c[p] = (wr_c[p] && hit_c[p]) ? hit_way_c[p] : vict_c[p];
        end
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            win_c[p] = wr_c[p];
            for (int q = 0; q < p; q++) begin
                if (wr_c[q] && (idx_c[q] == idx_c[p])) begin
                    win_c[p] = 1'b0;
                end
            end
        end
    end

    // Fills see same-edge winning writes; losing writers see their copy killed.
    always_comb begin
        for (int q = 0; q < NP; q++) begin
            fill_data_c[q] = mem_q[idx_c[q]];
            xinv_c[q]      = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (win_c[p] && (idx_c[p] == idx_c[q])) begin
                    fill_data_c[q] = din_in[p];
                end
                if ((p != q) && win_c[p] && (set_c[p] == set_c[q]) && (tag_c[p] == tag_c[q])) begin
                    xinv_c[q] = 1'b1;
                end
            end
            line_data_c[q] = fill_c[q] ? fill_data_c[q] : din_in[q];
        end
    end

    always_ff @(posedge plusclk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                state_q[p]     <= ST_IDLE;
                fill_addr_q[p] <= '0;
                dout_q[p]      <= '0;
                for (int s = 0; s < NSETS; s++) begin
                    valid_q[p][s] <= '0;
                    ptr_q[p][s]   <= '0;
                end
            end
        end else begin
            for (int q = 0; q < NP; q++) begin
                for (int p = 0; p < NP; p++) begin
                    if ((p != q) && win_c[p]) begin
                        for (int w = 0; w < NW; w++) begin
                            if (valid_q[q][set_c[p]][w] && (tag_q[q][set_c[p]][w] == tag_c[p])) begin
                                valid_q[q][set_c[p]][w] <= 1'b0;
                            end
                        end
                    end
                end
                if (wr_c[q]) begin
                    valid_q[q][set_c[q]][inst_way_c[q]] <= !xinv_c[q];
                    if (!hit_c[q] && evict_c[q]) begin
                        ptr_q[q][set_c[q]] <= ptr_q[q][set_c[q]] + 2'd1;
                    end
                end
                if (rd_c[q]) begin
                    if (hit_c[q]) begin
                        dout_q[q] <= hit_data_c[q];
                    end else begin
                        state_q[q]     <= ST_FILL;
                        fill_addr_q[q] <= addr_in[q][LOW_W-1:0];
                    end
                end
                if (fill_c[q]) begin
                    valid_q[q][set_c[q]][vict_c[q]] <= 1'b1;
                    if (evict_c[q]) begin
                        ptr_q[q][set_c[q]] <= ptr_q[q][set_c[q]] + 2'd1;
                    end
                    dout_q[q]  <= fill_data_c[q];
                    state_q[q] <= ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge plusclk) begin
        for (int q = 0; q < NP; q++) begin
            if (wr_c[q] || fill_c[q]) begin
                tag_q[q][set_c[q]][inst_way_c[q]]  <= tag_c[q];
                data_q[q][set_c[q]][inst_way_c[q]] <= line_data_c[q];
            end
        end
    end

    always_ff @(posedge plusclk) begin
        for (int p = 0; p < NP; p++) begin
            if (win_c[p]) begin
                mem_q[idx_c[p]] <= din_in[p];
            end
        end
    end

`ifdef HIT_STATUS_EN
    logic [NP-1:0] hit_q;

    always_ff @(posedge plusclk or posedge rst) begin
        if (rst) begin
            hit_q <= '0;
        end else begin
            hit_q <= (rd_c | wr_c) & hit_c;
        end
    end

    assign hit_proc = hit_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_hier_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_hier_top                                               |
// | Purpose  : directed self-checking bench for mem_hier_top.                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_mem_hier_top;

    localparam logic [31:0] IDLE_A = 32'h2000_0000;

    logic        plusclk;
    logic        rst;
    logic [31:0] addr0, addr1, addr2, addr3;
    logic [7:0]  din0, din1, din2, din3;
    logic [7:0]  dout0, dout1, dout2, dout3;
`ifdef HIT_STATUS_EN
    logic [3:0]  hit_proc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mem_hier_top dut (
        .plusclk     (plusclk),
        .rst         (rst),
        .addr_proc_0 (addr0),
        .addr_proc_1 (addr1),
        .addr_proc_2 (addr2),
        .addr_proc_3 (addr3),
        .din_proc_0  (din0),
        .din_proc_1  (din1),
        .din_proc_2  (din2),
        .din_proc_3  (din3),
        .dout_proc_0 (dout0),
        .dout_proc_1 (dout1),
        .dout_proc_2 (dout2),
        .dout_proc_3 (dout3)
`ifdef HIT_STATUS_EN
        ,
        .hit_proc    (hit_proc)
`endif
    );

    initial plusclk = 1'b0;
    always #5 plusclk = ~plusclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge plusclk);
        #1;
    endtask

    task automatic all_idle();
        addr0 = IDLE_A; addr1 = IDLE_A; addr2 = IDLE_A; addr3 = IDLE_A;
        din0 = 8'h00; din1 = 8'h00; din2 = 8'h00; din3 = 8'h00;
    endtask

    task automatic do_reset();
        all_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr0(input logic [31:0] a, input logic [7:0] d);
        addr0 = a; din0 = d;
        tick();
        addr0 = IDLE_A;
    endtask

    logic [31:0] set2_addr [5];
    logic [7:0]  set2_data [5];

    initial begin
        all_idle();
        do_reset();

        // Backing-store preload through port 0; reset afterwards drops the L1 copies.
        wr0(32'h1000_0002, 8'hAA);
        wr0(32'h1000_0005, 8'h3C);
        wr0(32'h1000_0012, 8'hB1);
        wr0(32'h1000_0022, 8'hB2);
        wr0(32'h1000_0032, 8'hB3);
        wr0(32'h1000_0042, 8'hB4);
        do_reset();

        check_val("rst_dout0", dout0, 32'h0);
        check_val("rst_dout1", dout1, 32'h0);
        check_val("rst_dout2", dout2, 32'h0);
        check_val("rst_dout3", dout3, 32'h0);

        // Read miss: two edges, then repeat read hits.
        addr0 = 32'h04B0_0002;
        tick(); check_val("miss_hold0", dout0, 32'h0);
`ifdef HIT_STATUS_EN
        check_val("hit_flag_miss", {28'h0, hit_proc}, 32'h0);
`endif
        tick(); check_val("miss_fill0", dout0, 32'hAA);
        tick(); check_val("rehit0", dout0, 32'hAA);
`ifdef HIT_STATUS_EN
        check_val("hit_flag_hit", {28'h0, hit_proc}, 32'h1);
`endif
        addr0 = 32'h14B0_0002; din0 = 8'h0F;
        tick(); check_val("wr_keeps_dout0", dout0, 32'hAA);
        addr0 = 32'h04B0_0002;
        tick(); check_val("wr_then_hit0", dout0, 32'h0F);

        // Coherence: proc1 copy is invalidated by a proc0 write.
        wr0(32'h14B0_0002, 8'hAA);
        addr1 = 32'h04B0_0002;
        tick(); check_val("p1_miss_hold", dout1, 32'h0);
        tick(); check_val("p1_fill", dout1, 32'hAA);
        addr1 = IDLE_A;
        wr0(32'h14B0_0002, 8'h55);
        addr1 = 32'h04B0_0002;
        tick(); check_val("p1_inval_hold", dout1, 32'hAA);
        tick(); check_val("p1_refill", dout1, 32'h55);

        // Same-edge read hit and foreign write: reader sees old data, then misses.
        addr0 = 32'h14B0_0002; din0 = 8'h66;
        tick(); check_val("rd_old_data", dout1, 32'h55);
        addr0 = IDLE_A;
        tick(); check_val("rd_after_inval_hold", dout1, 32'h55);
        tick(); check_val("rd_after_inval_fill", dout1, 32'h66);

        // Write lands on the edge proc1 completes its fill: forwarded, stays valid.
        addr1 = IDLE_A;
        wr0(32'h14B0_0002, 8'h70);
        addr1 = 32'h04B0_0002;
        tick(); check_val("fwd_fill_hold", dout1, 32'h66);
        addr0 = 32'h14B0_0002; din0 = 8'h77;
        tick(); check_val("fwd_fill_data", dout1, 32'h77);
        addr0 = IDLE_A;
        addr1 = 32'h0000_0005;
        tick(); check_val("p1_other_hold", dout1, 32'h77);
        tick(); check_val("p1_other_fill", dout1, 32'h3C);
        addr1 = 32'h04B0_0002;
        tick(); check_val("fwd_line_valid", dout1, 32'h77);
        addr1 = IDLE_A;

        // Five tags into set 2: fifth evicts way 0, pointer then names way 1.
        do_reset();
        set2_addr[0] = 32'h0000_0002; set2_data[0] = 8'h77;
        set2_addr[1] = 32'h0000_0012; set2_data[1] = 8'hB1;
        set2_addr[2] = 32'h0000_0022; set2_data[2] = 8'hB2;
        set2_addr[3] = 32'h0000_0032; set2_data[3] = 8'hB3;
        set2_addr[4] = 32'h0000_0042; set2_data[4] = 8'hB4;
        for (int i = 0; i < 5; i++) begin
            addr0 = set2_addr[i];
            tick();
            tick(); check_val($sformatf("set2_fill%0d", i), dout0, {24'h0, set2_data[i]});
        end
        addr0 = 32'h0000_0012;
        tick(); check_val("set2_hit_way1", dout0, 32'hB1);
        addr0 = 32'h0000_0002;
        tick(); check_val("set2_evicted_hold", dout0, 32'hB1);
        tick(); check_val("set2_evicted_fill", dout0, 32'h77);

        // Simultaneous writes to one index: lowest port wins, only it keeps a copy.
        do_reset();
        addr0 = 32'h14B0_0002; din0 = 8'h11;
        addr2 = 32'h14B0_0002; din2 = 8'h22;
        tick();
        addr0 = 32'h04B0_0002;
        addr2 = 32'h04B0_0002;
        tick();
        check_val("win_p0_hit", dout0, 32'h11);
        check_val("lose_p2_hold", dout2, 32'h0);
        tick(); check_val("lose_p2_fill", dout2, 32'h11);
        all_idle();

        // Asynchronous reset in the middle of a fill.
        do_reset();
        addr3 = 32'h0000_0012;
        tick();
        tick(); check_val("p3_pre_fill", dout3, 32'hB1);
        addr3 = 32'h0000_0005;
        tick(); check_val("p3_fill_pending", dout3, 32'hB1);
        #2 rst = 1'b1;
        #1 check_val("async_rst_dout3", dout3, 32'h0);
        @(posedge plusclk);
        #1 rst = 1'b0;
        tick(); check_val("post_rst_miss_hold", dout3, 32'h0);
        tick(); check_val("post_rst_fill", dout3, 32'h3C);
        all_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_hier_top.md
Name: mem_hier_top

Overview:
- Four-processor memory-hierarchy top level.
- Each processor port has a private 4-way set-associative L1 cache.
- All four L1s share one backing store and are kept coherent with write-through plus write-invalidate.
- Sits between the four processor models and the memory; processor operation type is encoded in the address.

Parameters:
ADDR_WIDTH, 32, processor address width
DATA_WIDTH, 8, data word width (one word per cache line)
SET_BITS, 4, log2 of sets per L1 (16 sets)
MEM_AW, 10, backing-store address bits (1024 words)

Ports:
plusclk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
addr_proc_0..addr_proc_3  in  ADDR_WIDTH each  processor address + opcode
din_proc_0..din_proc_3  in  DATA_WIDTH each  processor write data
dout_proc_0..dout_proc_3  out  DATA_WIDTH each  registered read data

Behaviour:
- Address fields per port:
  - [31:30] processor id, ignored.
  - [29:28] opcode: 00 read, 01 write, 10/11 idle.
  - [SET_BITS-1:0] set index.
  - [27:SET_BITS] tag.
  - [MEM_AW-1:0] backing-store index.
- L1 line content: valid bit, tag, DATA_WIDTH data. 4 ways; one 2-bit round-robin victim pointer per set.
- Victim selection: first invalid way, lowest index first; if all ways valid, the pointer way. The pointer increments only when a valid line is evicted.
- Backing store:
  - Combinational read, synchronous write.
  - Not cleared by reset.
  - Preloadable by hierarchical $readmemh.
- Per-port FSM states: IDLE and FILL.
- IDLE, read hit: dout <= hit data at the same rising edge (1-cycle latency).
- IDLE, read miss: latch address, go to FILL; dout holds.
- FILL, at the next edge:
  - Install the backing-store word (or same-edge forwarded write data, see below) in the victim way with valid set.
  - dout <= that word; return to IDLE.
  - Total miss latency is 2 edges; the processor holds its address for the duration.
  - Any request presented during FILL is ignored.
- IDLE, write (single edge):
  - mem[idx] <= din.
  - Own L1 updated on hit; on miss, allocated into the victim way (write-allocate).
  - Every matching valid line in the other three L1s is invalidated.
  - dout unchanged.
- Simultaneous writes to the same backing-store index: the lowest-numbered port wins the memory write. All writers' own lines still update with their own data, and the winner's write invalidates the others. Net rule: only the winner keeps a valid copy.
- Write on the same edge that another port completes FILL of a matching tag/index: the fill installs and returns the winning write data, and the line is not invalidated.
- Read hit on one port while another port writes the same line on the same edge: the reader gets the old data; its line is then invalidated.
- Reset (asynchronous, at any time including mid-FILL):
  - All valid bits, victim pointers and FSMs go to IDLE.
  - All dout go to 0.
  - A pending fill is dropped.
- No X propagation: unused or idle ports leave state untouched.

Optional Feature:
- Macro: HIT_STATUS_EN.
- When defined, adds output port hit_proc, 4 bits, one per port, registered.
  - Bit = 1 for the cycle after an IDLE read or write hit.
  - Bit = 0 after a miss, FILL completion, idle, or reset.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Preload mem[0x002]=0xAA; reset 1 cycle; proc0 addr 0x04B0_0002 (read) -> dout_proc_0 = 0xAA two edges after sampling; a repeat read hits in 1 edge.
- proc0 addr 0x14B0_0002, din 0x0F (write), then addr 0x04B0_0002 (read) -> mem[0x002]=0x0F; read hits; dout_proc_0 = 0x0F one edge later.
- proc1 reads 0x04B0_0002 (gets 0xAA); proc0 writes 0x55 to the same address; proc1 reads again -> miss (2 edges), dout_proc_1 = 0x55.
- proc0 reads five distinct tags in set 2 (0x0000_0002, 0x0000_0012, ... 0x0000_0042) -> all miss; the fifth evicts way 0; re-reading 0x0000_0002 misses, re-reading 0x0000_0012 hits.
- proc0 and proc2 write 0x11 / 0x22 to the same address on the same edge -> mem = 0x11; proc0 read hits 0x11; proc2 read misses and returns 0x11.
- Assert rst mid-FILL -> dout = 0 immediately; a subsequent read of the same address misses.
